// File: rtl/coder_pkg.sv
// coder_pkg: shared widths, encoder state type and popcount helper for the 8-to-3 coder pair.
package coder_pkg;
    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, BUSY} enc_state_t;

    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c += {{W{1'b0}}, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/priority_enc.sv
// priority_enc: index of the lowest (LSB_FIRST=1) or highest set bit; zero input yields 0.
module priority_enc #(
    parameter int N = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx
);
    // Later matches overwrite earlier ones, so scan order picks the winning end.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (LSB_FIRST && vec[N-1-i]) idx = W'(N-1-i);
            if (!LSB_FIRST && vec[i]) idx = W'(i);
        end
    end
endmodule

// File: rtl/encoder_8_to_3_serial.sv
// encoder_8_to_3_serial: accepts a multi-hot word and streams the index of each set bit,
// one per output handshake, with popcount and an all-zero-word pulse.
module encoder_8_to_3_serial #(
    parameter int N = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] D,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         last,
    output logic [W:0]   ones_cnt,
    output logic         zero_err
);
    import coder_pkg::*;

    enc_state_t   state;
    logic [N-1:0] pending;
    logic [W-1:0] idx;

    priority_enc #(.N(N), .LSB_FIRST(LSB_FIRST)) u_penc (
        .vec(pending),
        .idx(idx)
    );

    // Outputs derive only from registered state, never from out_ready.
    assign in_ready  = state == IDLE;
    assign out_valid = state == BUSY;
    assign y         = idx;
    assign last      = $onehot(pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            ones_cnt <= '0;
            zero_err <= 1'b0;
        end else begin
            zero_err <= in_valid && in_ready && D == '0;
            if (in_valid && in_ready) begin
                pending  <= D;
                ones_cnt <= popcount(D);
                state    <= D != '0 ? BUSY : IDLE;
            end else if (out_valid && out_ready) begin
                pending <= pending & ~(N'(1) << idx);
                state   <= last ? IDLE : BUSY;
            end
        end
    end
endmodule

// File: tb/tb_encoder_8_to_3_serial.sv
// tb_encoder_8_to_3_serial: drives LSB-first and MSB-first encoders in lockstep against
// per-word index queues built from the input word, with decoder-style loopback.
module tb_encoder_8_to_3_serial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] D = '0;

    logic       in_ready1, out_valid1, last1, zero_err1;
    logic [2:0] y1;
    logic [3:0] ones_cnt1;
    logic       in_ready0, out_valid0, last0, zero_err0;
    logic [2:0] y0;
    logic [3:0] ones_cnt0;

    always #5 clk = ~clk;

    encoder_8_to_3_serial #(.LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .D(D),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .last(last1),
        .ones_cnt(ones_cnt1), .zero_err(zero_err1)
    );

    encoder_8_to_3_serial #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .D(D),
        .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .last(last0),
        .ones_cnt(ones_cnt0), .zero_err(zero_err0)
    );

    int vectors = 0;
    int miscompares = 0;
    int q1[$];
    int q0[$];

    typedef struct {
        logic [7:0] d;
        int         cnt;
        int         f1;
        int         f0;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1 with both encoders idle; returns at posedge+1 with both idle again.
    // mode >= 0: percent chance of stalling each cycle; mode < 0: out_ready pattern 1,0,0,...
    task automatic run_word(input logic [7:0] d, input int mode,
                            output int beats, output int first1, output int first0);
        logic [7:0] recon1, recon0;
        int cyc;
        q1.delete();
        q0.delete();
        for (int i = 0; i < 8; i++) if (d[i]) q1.push_back(i);
        for (int i = 7; i >= 0; i--) if (d[i]) q0.push_back(i);
        beats = 0;
        first1 = -1;
        first0 = -1;
        recon1 = '0;
        recon0 = '0;
        in_valid = 1'b1;
        D = d;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_idle", in_ready1, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        D = 8'($urandom);
        if (d == 8'h00) begin
            @(negedge clk);
            chk("zero_err_pulse", zero_err1, 1);
            chk("zero_err_pulse_msb", zero_err0, 1);
            chk("zero_out_valid", out_valid1, 0);
            chk("zero_in_ready", in_ready1, 1);
            chk("zero_ones_cnt", ones_cnt1, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("zero_err_clear", zero_err1, 0);
            chk("zero_out_valid_2", out_valid1, 0);
            @(posedge clk); #1;
            return;
        end
        for (cyc = 0; cyc < 200; cyc++) begin
            out_ready = mode < 0 ? (cyc % 3 == 0) : ($urandom_range(99) >= mode);
            @(negedge clk);
            chk("ones_cnt_lsb", ones_cnt1, $countones(d));
            chk("ones_cnt_msb", ones_cnt0, $countones(d));
            if (q1.size() == 0) begin
                chk("word_done_out_valid", out_valid1, 0);
                chk("word_done_in_ready", in_ready1, 1);
                chk("word_done_out_valid_msb", out_valid0, 0);
                break;
            end
            chk("busy_out_valid", out_valid1, 1);
            chk("busy_in_ready", in_ready1, 0);
            chk("y_lsb", y1, q1[0]);
            chk("last_lsb", last1, q1.size() == 1);
            chk("y_msb", y0, q0[0]);
            chk("last_msb", last0, q0.size() == 1);
            if (out_ready) begin
                if (beats == 0) begin
                    first1 = int'(y1);
                    first0 = int'(y0);
                end
                recon1 |= 8'(1) << y1;
                recon0 |= 8'(1) << y0;
                beats++;
                void'(q1.pop_front());
                void'(q0.pop_front());
            end
            @(posedge clk); #1;
        end
        if (cyc >= 200) chk("word_timeout", cyc, 0);
        else begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("beats_vs_ones_cnt", beats, ones_cnt1);
        chk("loopback_lsb", recon1, d);
        chk("loopback_msb", recon0, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[7];
        int beats, f1, f0;
        tbl[0] = '{8'h01, 1, 0, 0};
        tbl[1] = '{8'hA4, 3, 2, 7};
        tbl[2] = '{8'hFF, 8, 0, 7};
        tbl[3] = '{8'h80, 1, 7, 7};
        tbl[4] = '{8'h18, 2, 3, 4};
        tbl[5] = '{8'h00, 0, -1, -1};
        tbl[6] = '{8'h42, 2, 1, 6};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_y", y1, 0);
        chk("rst_last", last1, 0);
        chk("rst_ones_cnt", ones_cnt1, 0);
        chk("rst_zero_err", zero_err1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_word(tbl[i].d, 0, beats, f1, f0);
            chk("tbl_beats", beats, tbl[i].cnt);
            chk("tbl_first_lsb", f1, tbl[i].f1);
            chk("tbl_first_msb", f0, tbl[i].f0);
        end

        run_word(8'hA4, -1, beats, f1, f0);
        chk("stall_pattern_beats", beats, 3);
        chk("stall_pattern_first_msb", f0, 7);

        // A word offered while busy must be ignored and outputs must hold while stalled.
        in_valid = 1'b1;
        D = 8'h81;
        @(posedge clk); #1;
        D = 8'h0F;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("busy_ignore_y_lsb", y1, 0);
            chk("busy_ignore_y_msb", y0, 7);
            chk("busy_ignore_in_ready", in_ready1, 0);
            chk("busy_ignore_ones_cnt", ones_cnt1, 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("busy_drain_y0", y1, 0);
        chk("busy_drain_last0", last1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_drain_y1", y1, 7);
        chk("busy_drain_last1", last1, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_drain_idle", out_valid1, 0);
        chk("busy_drain_ones_cnt", ones_cnt1, 2);
        out_ready = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset mid-word discards the remaining indices.
        in_valid = 1'b1;
        D = 8'hFF;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ff_beat_y", y1, i);
            chk("ff_beat_last", last1, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid1, 0);
        chk("async_rst_in_ready", in_ready1, 1);
        chk("async_rst_ones_cnt", ones_cnt1, 0);
        chk("async_rst_last", last1, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_word(8'h10, 0, beats, f1, f0);
        chk("post_rst_beats", beats, 1);
        chk("post_rst_y", f1, 4);

        for (int d = 0; d < 256; d++) run_word(8'(d), int'($urandom_range(50)), beats, f1, f0);
        repeat (30) run_word(8'($urandom), int'($urandom_range(70)), beats, f1, f0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/encoder_8_to_3_serial.md
Name: encoder_8_to_3_serial

Overview:
- Inverse of the team's 3-to-8 decoder. Accepts an 8-bit multi-hot word `D` over a valid/ready handshake and emits the 3-bit index `y` of each set bit, one index per accepted output beat.
- Serves as the encode side wherever decoded one-hot/multi-hot request lines must be turned back into binary indices, e.g. request vector -> sequential grant index stream.
- The decoder and this block together form a closed loop for verification.

Parameters:
- N, 8, input word width; must be a power of 2 and ≥2.
- W, $clog2(N) (3), index width; derived, never overridden.
- LSB_FIRST, 1, 1 = emit indices lowest-first; 0 = highest-first.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  `D` is valid
- in_ready  out  1  block can accept a word (combinational from state)
- D  in  N  multi-hot input word
- out_valid  out  1  `y` holds a valid index
- out_ready  in  1  downstream accepts `y`
- y  out  W  binary index of current set bit
- last  out  1  current `y` is the final index of the word
- ones_cnt  out  W+1  popcount of the accepted word, held until next accept
- zero_err  out  1  one-cycle pulse: an all-zero word was accepted

Behaviour:
- Reset is asynchronous, active-low. On assertion:
  - state=IDLE, pending=0, out_valid=0, y=0, last=0, ones_cnt=0, zero_err=0.
  - Takes effect immediately, including mid-word; the remaining indices are discarded.
- States: IDLE, BUSY.
- IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid=1 and D!=0: pending<=D, ones_cnt<=popcount(D), go to BUSY.
  - If in_valid=1 and D==0: word consumed, zero_err=1 for next cycle only, ones_cnt<=0, stay in IDLE.
- BUSY:
  - in_ready=0, out_valid=1.
  - y = index of lowest set bit of pending (highest if LSB_FIRST=0).
  - last=1 when pending has exactly one bit set.
  - `y` and `last` are registered/state-derived only; there is no combinational path from out_ready to y.
- Output transfer occurs on a cycle with out_valid && out_ready:
  - Clear the served bit in pending.
  - If last=1, go to IDLE.
  - If out_ready=0, y/last/out_valid hold stable (AXI-style: no retraction, no change while stalled).
- Latency: first index valid 1 cycle after input accept. With out_ready held high, one index per cycle. Word with k set bits occupies k cycles in BUSY, then 1 IDLE cycle before the next accept (no back-to-back overlap).
- Boundary conditions:
  - D=8'hFF: emits 0..7 (LSB_FIRST=1), last on the 8th beat.
  - Single-bit D: one beat with last=1.
  - in_valid asserted during BUSY is ignored (in_ready=0); the source must hold it.
- Invariants:
  - Between accepts, ones_cnt equals the number of beats emitted for that word.
  - Feeding every emitted y through decoder_3_to_8 and OR-ing the results reconstructs the accepted D.

Decomposition:
- Shared package coder_pkg:
  - Localparams N=8 and W=3.
  - enc_state_t enum {IDLE, BUSY}.
  - Function popcount(N-bit) returning W+1 bits.
- One combinational sub-module, priority_enc (N-bit in, W-bit index out, LSB_FIRST parameter), instantiated on pending.
- FSM, pending register and handshake logic stay in the top.

Test Plan:
- Reset, then in_valid=1, D=8'b0000_0001, out_ready=1 -> next cycle out_valid=1, y=0, last=1, ones_cnt=1; following cycle in_ready=1.
- D=8'b1010_0100, out_ready=1, LSB_FIRST=1 -> y=2,5,7 on consecutive cycles; last=1 only with y=7; ones_cnt=3.
- Same D with LSB_FIRST=0 -> y=7,5,2; out_ready toggled 1,0,0,1,... -> y stable during stall cycles, no beats lost or duplicated.
- D=8'h00 accepted -> zero_err high exactly one cycle, out_valid stays 0, in_ready stays 1.
- D=8'hFF, rst_n pulsed low after the third beat (y=2) -> out_valid=0 and in_ready=1 immediately; next D=8'h10 yields a single y=4, last=1.
- Loopback: all 256 D values through this block into decoder_3_to_8 -> OR of decoder outputs equals D for every word; beat count equals ones_cnt.
